mmio_responder: RTL and testbench

//  Bus responder for the enhanced processor's memory port: answers ADDR/DOUT/W transactions and returns read data on DIN.

---
 rtl/mmio_responder_pkg.sv | 45 ++++
 rtl/mmio_responder_if.sv | 32 +++
 rtl/mmio_responder_sync_fifo.sv | 57 +++++
 rtl/mmio_responder.sv | 148 ++++++++++++++
 tb/tb_mmio_responder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_responder_pkg.sv
// Shared address map, status-word layout and address decode for the MMIO responder.
package mmio_responder_pkg;

    // Peripheral word addresses (addr[7]=1 region)
    localparam logic [7:0] MMIO_LED = 8'h80;
    localparam logic [7:0] MMIO_SW  = 8'h90;
    localparam logic [7:0] MMIO_TXD = 8'hA0;
    localparam logic [7:0] MMIO_TXS = 8'hA1;
    localparam logic [7:0] MMIO_TMR = 8'hB0;

    // TXS status word layout
    localparam int unsigned TXS_FULL_BIT = 0;
    localparam int unsigned TXS_OVF_BIT  = 1;
    localparam int unsigned TXS_CNT_LSB  = 2;
    localparam int unsigned TXS_CNT_W    = 6;

    typedef enum logic [2:0] {
        SelRam,
        SelLed,
        SelSw,
        SelTxd,
        SelTxs,
        SelTmr,
        SelNone
    } sel_e;

    // Map a word address onto the target it selects
    function automatic sel_e mmio_decode(input logic [7:0] addr);
        sel_e sel;
        if (!addr[7]) begin
            sel = SelRam;
        end else begin
            case (addr)
                MMIO_LED: sel = SelLed;
                MMIO_SW:  sel = SelSw;
                MMIO_TXD: sel = SelTxd;
                MMIO_TXS: sel = SelTxs;
                MMIO_TMR: sel = SelTmr;
                default:  sel = SelNone;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// Processor memory-port bus plus the output character stream handshake.
interface mmio_responder_if;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        wr;
    logic [15:0] rdata;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    // Processor / stream consumer side
    modport master (
        output addr,
        output wdata,
        output wr,
        output tx_ready,
        input  rdata,
        input  tx_data,
        input  tx_valid
    );

    // Responder side
    modport slave (
        input  addr,
        input  wdata,
        input  wr,
        input  tx_ready,
        output rdata,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/mmio_responder_sync_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only alongside a pop.
module mmio_responder_sync_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_data,
    output logic [W-1:0]               o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    // Zero when empty so the stream output is deterministic
    assign o_head  = o_empty ? '0 : r_mem[r_rptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage is not reset; head is masked while empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: data RAM, LED register, switch readback, TX FIFO and millisecond timer.
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PRESCALE   = 50000,
    parameter int unsigned LED_W      = 9
) (
    input  logic                 clk_50MHz,
    input  logic                 reset_n,
    mmio_responder_if.slave      bus,
    input  logic [LED_W-1:0]     sw,
    output logic [LED_W-1:0]     led
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PW = $clog2(PRESCALE);

    sel_e                 w_sel;
    logic                 w_wr_led;
    logic                 w_wr_txd;
    logic                 w_wr_txs;
    logic                 w_wr_tmr;
    logic                 w_wr_ram;
    logic [15:0]          w_rd_mux;
    logic [15:0]          w_txs;
    logic [TXS_CNT_W-1:0] w_cnt;
    logic [CW-1:0]        w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_tick;

    logic [15:0]          r_ram [128];
    logic [15:0]          r_rdata;
    logic [LED_W-1:0]     r_led;
    logic [LED_W-1:0]     r_sw_meta;
    logic [LED_W-1:0]     r_sw_sync;
    logic                 r_ovf;
    logic [15:0]          r_tmr;
    logic [PW-1:0]        r_pre;

    assign w_sel    = mmio_decode(bus.addr);
    assign w_wr_ram = bus.wr & (w_sel == SelRam);
    assign w_wr_led = bus.wr & (w_sel == SelLed);
    assign w_wr_txd = bus.wr & (w_sel == SelTxd);
    assign w_wr_txs = bus.wr & (w_sel == SelTxs);
    assign w_wr_tmr = bus.wr & (w_sel == SelTmr);
    assign w_pop    = ~w_empty & bus.tx_ready;
    assign w_tick   = (r_pre == PW'(PRESCALE - 1));

    assign bus.rdata    = r_rdata;
    assign bus.tx_valid = ~w_empty;
    assign led          = r_led;

    mmio_responder_sync_fifo #(
        .W     (16),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk_50MHz),
        .rst_n   (reset_n),
        .i_push  (w_wr_txd),
        .i_pop   (bus.tx_ready),
        .i_data  (bus.wdata),
        .o_head  (bus.tx_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Data RAM write port; not reset, read path goes through r_rdata
    always_ff @(posedge clk_50MHz) begin
        if (w_wr_ram) r_ram[bus.addr[6:0]] <= bus.wdata;
    end

    // Assemble the TX status word
    always_comb begin
        w_cnt                  = TXS_CNT_W'(w_count);
        w_txs                  = '0;
        w_txs[TXS_FULL_BIT]    = w_full;
        w_txs[TXS_OVF_BIT]     = r_ovf;
        w_txs[TXS_CNT_LSB +: TXS_CNT_W] = w_cnt;
    end

    // Read mux; registered into r_rdata every cycle, no read side effects
    always_comb begin
        w_rd_mux = '0;
        unique case (w_sel)
            SelRam:  w_rd_mux = r_ram[bus.addr[6:0]];
            SelLed:  w_rd_mux = 16'(r_led);
            SelSw:   w_rd_mux = 16'(r_sw_sync);
            SelTxs:  w_rd_mux = w_txs;
            SelTmr:  w_rd_mux = r_tmr;
            default: w_rd_mux = '0;
        endcase
    end

    // Registered read data; RAM read-during-write returns the old word
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) r_rdata <= '0;
        else          r_rdata <= w_rd_mux;
    end

    // LED register
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n)      r_led <= '0;
        else if (w_wr_led) r_led <= bus.wdata[LED_W-1:0];
    end

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Sticky overflow: set when a push is dropped, cleared by any TXS write
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_wr_txs) begin
            r_ovf <= 1'b0;
        end else if (w_wr_txd && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    // Prescaled timer; a TMR write overrides a coincident tick
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_tmr <= '0;
            r_pre <= '0;
        end else if (w_wr_tmr) begin
            r_tmr <= bus.wdata;
            r_pre <= '0;
        end else if (w_tick) begin
            r_tmr <= r_tmr + 16'd1;
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Randomised scoreboard bench for mmio_responder against a transaction-level model.
module tb_mmio_responder;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned PRESCALE   = 4;
    localparam int unsigned LED_W      = 9;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [15:0] exp;
    } rd_t;

    typedef struct {
        int          cyc;
        logic        txv;
        logic [15:0] txd;
        logic [8:0]  led;
    } st_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [LED_W-1:0] tb_sw = '0;
    logic [LED_W-1:0] led;
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_fail = 0;

    mmio_responder_if bus ();

    mmio_responder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .PRESCALE   (PRESCALE),
        .LED_W      (LED_W)
    ) dut (
        .clk_50MHz (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .sw        (tb_sw),
        .led       (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state (state after edge 'cyc')
    logic [15:0] m_ram [128];
    logic [8:0]  m_led;
    logic [15:0] m_fifo [$];
    bit          m_ovf;
    logic [15:0] tmr_v;
    int          tmr_e;
    int          rel_c;
    logic [8:0]  sw_hist [int];

    rd_t rd_q [$];
    st_t st_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [7:0] a, input int c);
        int sz;
        sz = m_fifo.size();
        if (!a[7]) return m_ram[a[6:0]];
        case (a)
            8'h80: return 16'(m_led);
            8'h90: return (c - 2 >= rel_c) ? 16'(sw_hist[c - 2]) : 16'h0;
            8'hA1: return 16'(sz * 4 + (m_ovf ? 2 : 0) + (sz == FIFO_DEPTH ? 1 : 0));
            8'hB0: return 16'(int'(tmr_v) + (c - tmr_e) / PRESCALE);
            default: return 16'h0;
        endcase
    endfunction

    // One bus cycle: drive inputs, record expectations, advance the model by one edge
    task automatic issue(input logic [7:0] a, input logic [15:0] d, input bit w, input bit rdy);
        int c;
        bit pop;
        c = cyc;
        bus.addr     = a;
        bus.wdata    = d;
        bus.wr       = w;
        bus.tx_ready = rdy;
        rd_q.push_back('{cyc: c, addr: a, exp: model_read(a, c)});
        st_q.push_back('{cyc: c, txv: (m_fifo.size() > 0),
                         txd: (m_fifo.size() > 0) ? m_fifo[0] : 16'h0, led: m_led});
        sw_hist[c] = tb_sw;
        pop = (m_fifo.size() > 0) && rdy;
        if (pop) void'(m_fifo.pop_front());
        if (w) begin
            if (!a[7]) begin
                m_ram[a[6:0]] = d;
            end else begin
                case (a)
                    8'h80: m_led = d[8:0];
                    8'hA0: begin
                        if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(d);
                        else m_ovf = 1'b1;
                    end
                    8'hA1: m_ovf = 1'b0;
                    8'hB0: begin
                        tmr_v = d;
                        tmr_e = c + 1;
                    end
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #2;
    endtask

    // Assert reset during an in-flight LED write, release and check reset values
    task automatic apply_reset();
        bus.addr  = 8'h80;
        bus.wdata = 16'h01FF;
        bus.wr    = 1'b1;
        #1;
        reset_n = 1'b0;
        rd_q.delete();
        st_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        rel_c   = cyc;
        m_led   = '0;
        m_fifo.delete();
        m_ovf   = 1'b0;
        tmr_v   = '0;
        tmr_e   = cyc;
        sw_hist.delete();
        #1;
        check("reset_led", 32'(led), 32'h0);
        check("reset_rdata", 32'(bus.rdata), 32'h0);
        check("reset_tx_valid", 32'(bus.tx_valid), 32'h0);
        issue(8'hA1, 16'h0, 1'b0, 1'b0);
    endtask

    // Monitor: compare DUT outputs with queued expectations, away from the active edge
    always @(negedge clk) begin
        rd_t r;
        st_t s;
        if (reset_n) begin
            while (rd_q.size() > 0 && rd_q[0].cyc < cyc - 1) begin
                r = rd_q.pop_front();
                check("rdata_missed", 32'(r.cyc), 32'(cyc - 1));
            end
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc - 1) begin
                r = rd_q.pop_front();
                check($sformatf("rdata@%02h", r.addr), 32'(bus.rdata), 32'(r.exp));
            end
            if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
                s = st_q.pop_front();
                check("tx_valid", 32'(bus.tx_valid), 32'(s.txv));
                check("tx_data", 32'(bus.tx_data), 32'(s.txd));
                check("led", 32'(led), 32'(s.led));
            end
        end
    end

    initial begin
        logic [7:0] a;
        bus.addr = '0;
        bus.wdata = '0;
        bus.wr = 1'b0;
        bus.tx_ready = 1'b0;
        @(posedge clk);
        #2;
        apply_reset();

        // Initialise all RAM words so any later read is predictable
        for (int i = 0; i < 128; i++) issue(8'(i), 16'($urandom), 1'b1, 1'b0);

        // RAM directed, including read-during-write and LED aliasing
        issue(8'h05, 16'h1234, 1'b1, 1'b0);
        issue(8'h7F, 16'hBEEF, 1'b1, 1'b0);
        issue(8'h05, 16'h0, 1'b0, 1'b0);
        issue(8'h7F, 16'h0, 1'b0, 1'b0);
        issue(8'h85, 16'h0, 1'b0, 1'b0);
        issue(8'h05, 16'hAAAA, 1'b1, 1'b0);
        issue(8'h05, 16'h0, 1'b0, 1'b0);

        // LED and switches
        issue(8'h80, 16'h01FF, 1'b1, 1'b0);
        issue(8'h80, 16'h0, 1'b0, 1'b0);
        issue(8'h90, 16'hFFFF, 1'b1, 1'b0);
        tb_sw = 9'h0A5;
        repeat (4) issue(8'h90, 16'h0, 1'b0, 1'b0);

        // FIFO fill to full, overflow, drain, clear
        for (int i = 1; i <= 9; i++) begin
            issue(8'hA0, 16'(i), 1'b1, 1'b0);
            if (i >= 8) issue(8'hA1, 16'h0, 1'b0, 1'b0);
        end
        issue(8'hA0, 16'h0, 1'b0, 1'b0);
        repeat (10) issue(8'hA1, 16'h0, 1'b0, 1'b1);
        issue(8'hA1, 16'h0, 1'b1, 1'b0);
        issue(8'hA1, 16'h0, 1'b0, 1'b0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) issue(8'hA0, 16'(16'h100 + i), 1'b1, 1'b0);
        issue(8'hA0, 16'h0055, 1'b1, 1'b1);
        issue(8'hA1, 16'h0, 1'b0, 1'b0);
        repeat (10) issue(8'hA1, 16'h0, 1'b0, 1'b1);

        // Timer wrap, then a write landing on a tick edge
        issue(8'hB0, 16'hFFFE, 1'b1, 1'b0);
        repeat (10) issue(8'hB0, 16'h0, 1'b0, 1'b0);
        issue(8'hB0, 16'h1000, 1'b1, 1'b0);
        repeat (3) issue(8'hB0, 16'h0, 1'b0, 1'b0);
        issue(8'hB0, 16'h2000, 1'b1, 1'b0);
        repeat (6) issue(8'hB0, 16'h0, 1'b0, 1'b0);

        // Randomised traffic across the whole map
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    a = {1'b0, 7'($urandom)};
                2:       a = 8'h80;
                3:       a = 8'h90;
                4:       a = 8'hA0;
                5:       a = 8'hA1;
                6:       a = 8'hB0;
                default: a = 8'h80 | 8'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) tb_sw = 9'($urandom);
            issue(a, 16'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0));
        end

        // Second reset with a non-empty state, then confirm cleared state
        for (int i = 0; i < 3; i++) issue(8'hA0, 16'(16'h700 + i), 1'b1, 1'b0);
        apply_reset();
        issue(8'h80, 16'h0, 1'b0, 1'b0);
        issue(8'hB0, 16'h0, 1'b0, 1'b0);
        issue(8'h7F, 16'h0, 1'b0, 1'b0);
        issue(8'h00, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(rd_q.size() + st_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
